mp_addsub_seq: RTL
==================

Name: mp_addsub_seq

Overview:
- Multi-precision add/subtract sequencer around one `addsub` instance.
- Streams operand word pairs least-significant first and drives `addsub` `sub`/`cin`/`carry` per word. It chains `cout` between words and streams result words out.
- Reports the final carry/borrow and zero flags.
- Sits between the operand fetch logic and the result writeback in the arithmetic unit.

Parameters:
- LEN_W, 4, width of the command length field; max operation length is 2**LEN_W words.
- WORD_SIZE is not a parameter of this block. It comes from the shared `lib/params.vh` include, as in every `lib` block.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- op_sub  in  1  1 = x - y, 0 = x + y.
- op_use_cin  in  1  add only: word 0 uses op_cin as carry-in (ADC). Ignored when op_sub=1.
- op_cin  in  1  external carry-in for ADC.
- op_len  in  LEN_W  number of words minus 1 (0 means 1 word).
- in_valid  in  1  operand word pair valid.
- in_ready  out  1  sequencer accepts the operand pair this cycle.
- in_x  in  WORD_SIZE  minuend/augend word.
- in_y  in  WORD_SIZE  subtrahend/addend word.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_sum  out  WORD_SIZE  result word.
- out_last  out  1  marks the most-significant result word.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last result word is accepted.
- flag_c  out  1  final carry. For subtract, 1 = no borrow (x >= y unsigned).
- flag_z  out  1  all result words were zero.

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs are 0: in_ready, out_valid, out_sum, out_last, busy, done, flag_c, flag_z. carry_q=0, word counter=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches op_sub, op_use_cin, op_cin and op_len, clears the word counter, and sets zero_acc=1.
  - Next state is RUN. busy rises the following cycle.
- RUN:
  - in_ready = !out_valid || out_ready (one-deep output register, full throughput).
  - An operand transfer happens when in_valid && in_ready.
- Per-word `addsub` drive on a transfer:
  - Word 0: sub=op_sub, carry=op_use_cin && !op_sub, cin=op_cin, y=in_y.
  - Word k>0: sub=0, carry=1, cin=carry_q, y = op_sub ? ~in_y : in_y. This chains the borrow, since `addsub` forces cin=1 whenever sub=1.
- Capture on transfer:
  - out_sum <= sum; out_valid <= 1; carry_q <= cout.
  - zero_acc <= zero_acc && (sum==0).
  - out_last <= (counter==op_len); counter increments.
- Last word: when the last word transfers, the next state is DRAIN.
- Output hold: out_valid stays asserted with out_sum and out_last stable until out_ready. It is cleared on out_ready when no new transfer lands in the same cycle.
- Latency: result word appears 1 cycle after its operand transfer.
- DRAIN:
  - in_ready=0.
  - When out_valid && out_ready && out_last: flag_c <= carry_q, flag_z <= zero_acc, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. flag_c and flag_z hold until the next command's DONE or reset.
- start outside IDLE is ignored; the command is not queued.
- Stalls: in_valid low mid-operation stalls with no state change. out_ready low backpressures in_ready in the same cycle.
- Length limits:
  - op_len=0 gives a single word, so word 0 is also last.
  - op_len=2**LEN_W-1 gives the maximum length; the counter must not wrap before out_last.
- Reset mid-operation aborts immediately with no done pulse. Partial results are discarded by downstream via busy falling.
- Width rule: `addsub` is combinational and must be driven only from the registered op fields and the in_* ports. There is no combinational path from out_ready to the addsub inputs.

Decomposition:
- Shared package/include (`lib/params.vh` or the adjacent sequencer include):
  - state encoding constants ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE.
  - default LEN_W.
- One sub-module: the existing `addsub`, instantiated once. No other hierarchy.

Test Plan:
- Values are shown for WORD_SIZE=16.
- Add, 1 word: op_len=0, x=0x1234, y=0x0001 -> out_sum=0x1235, out_last=1, flag_c=0, flag_z=0, done 1 cycle after acceptance.
- Add with carry propagation, 3 words:
  - x words = {0xFFFF, 0xFFFF, 0x0000}, y words = {0x0001, 0x0000, 0x0000}.
  - -> result {0x0000, 0x0000, 0x0001}, flag_c=0, flag_z=0.
- Subtract with borrow chain, 2 words:
  - x words = {0x0000, 0x0001}, y words = {0x0001, 0x0000}.
  - -> result {0xFFFF, 0x0000}, flag_c=1 (no final borrow).
  - Repeat with x=0, y=1 (2 words) -> result {0xFFFF, 0xFFFF}, flag_c=0, flag_z=0.
- ADC and zero flag:
  - op_use_cin=1, op_cin=1, x=0xFFFF, y=0x0000, op_len=0 -> out_sum=0x0000, flag_c=1, flag_z=1.
  - Same stimulus with op_sub=1 -> op_cin ignored; x - y = 0xFFFF, flag_c=1.
- Backpressure and stalls:
  - 4-word add with random in_valid gaps and out_ready held low for 5 cycles mid-stream.
  - -> no word lost or duplicated, out_sum stable while stalled, in_ready=0 while out_valid && !out_ready.
  - start pulsed during RUN is ignored.
- Reset mid-operation: deassert rst_n asynchronously after word 1 of 4 -> all outputs 0 immediately, no done. A new command after release completes correctly.

Source files
------------

// File: rtl/mp_addsub_seq_pkg.sv
// Shared constants and state encoding for the multi-precision add/subtract sequencer.
package mp_addsub_seq_pkg;

   localparam int unsigned WORD_SIZE     = 16;
   localparam int unsigned DEFAULT_LEN_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/mp_addsub_seq_addsub.sv
// Combinational word adder/subtractor; subtraction always injects a carry-in of 1.
module addsub
   import mp_addsub_seq_pkg::*;
(
   input  logic [WORD_SIZE-1:0] x,
   input  logic [WORD_SIZE-1:0] y,
   input  logic                 sub,
   input  logic                 carry,
   input  logic                 cin,
   output logic [WORD_SIZE-1:0] sum,
   output logic                 cout
);

   logic [WORD_SIZE-1:0] y_eff;
   logic                 c0;
   logic [WORD_SIZE:0]   wide;

   always_comb begin
      y_eff = sub ? ~y : y;
      c0    = sub ? 1'b1 : (carry & cin);
      wide  = {1'b0, x} + {1'b0, y_eff} + {{WORD_SIZE{1'b0}}, c0};
   end

   assign sum  = wide[WORD_SIZE-1:0];
   assign cout = wide[WORD_SIZE];

endmodule

// File: rtl/mp_addsub_seq.sv
// Streams operand word pairs LS-first through one addsub, chaining carry/borrow between
// words, and reports final carry and all-zero flags.
module mp_addsub_seq
   import mp_addsub_seq_pkg::*;
#(
   parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic                 op_use_cin,
   input  logic                 op_cin,
   input  logic [LEN_W-1:0]     op_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_SIZE-1:0] in_x,
   input  logic [WORD_SIZE-1:0] in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_sum,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 flag_c,
   output logic                 flag_z
);

   state_e             state;
   logic               sub_q;
   logic               use_cin_q;
   logic               cin_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W:0]     count_q;  // one spare bit so the maximum length never wraps
   logic               carry_q;
   logic               zero_acc_q;

   logic               as_sub;
   logic               as_carry;
   logic               as_cin;
   logic [WORD_SIZE-1:0] as_y;
   logic [WORD_SIZE-1:0] as_sum;
   logic               as_cout;

   logic               first_word;
   logic               last_word;
   logic               xfer;

   assign in_ready   = (state == ST_RUN) && (!out_valid || out_ready);
   assign xfer       = in_valid && in_ready;
   assign first_word = (count_q == '0);
   assign last_word  = (count_q == {1'b0, len_q});

   // Words above 0 run as plain adds of ~y so the borrow can chain through cin.
   always_comb begin
      if (first_word) begin
         as_sub   = sub_q;
         as_carry = use_cin_q && !sub_q;
         as_cin   = cin_q;
         as_y     = in_y;
      end else begin
         as_sub   = 1'b0;
         as_carry = 1'b1;
         as_cin   = carry_q;
         as_y     = sub_q ? ~in_y : in_y;
      end
   end

   addsub u_addsub (
      .x     (in_x),
      .y     (as_y),
      .sub   (as_sub),
      .carry (as_carry),
      .cin   (as_cin),
      .sum   (as_sum),
      .cout  (as_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sub_q      <= 1'b0;
         use_cin_q  <= 1'b0;
         cin_q      <= 1'b0;
         len_q      <= '0;
         count_q    <= '0;
         carry_q    <= 1'b0;
         zero_acc_q <= 1'b0;
         out_valid  <= 1'b0;
         out_sum    <= '0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         flag_c     <= 1'b0;
         flag_z     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sub_q      <= op_sub;
                  use_cin_q  <= op_use_cin;
                  cin_q      <= op_cin;
                  len_q      <= op_len;
                  count_q    <= '0;
                  zero_acc_q <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  out_sum    <= as_sum;
                  out_valid  <= 1'b1;
                  out_last   <= last_word;
                  carry_q    <= as_cout;
                  zero_acc_q <= zero_acc_q && (as_sum == '0);
                  count_q    <= count_q + 1'b1;
                  if (last_word) begin
                     state <= ST_DRAIN;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_ready && out_last) begin
                  flag_c    <= carry_q;
                  flag_z    <= zero_acc_q;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
